// File: rtl/vfp_config_axil_master.sv
// vfp_config_axil_master: single-outstanding AXI4-Lite initiator with command/response port and per-transaction timeout
module vfp_config_axil_master #(
  parameter int C_vfpConfig_DATA_WIDTH = 32,
  parameter int C_vfpConfig_ADDR_WIDTH = 8,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                                  vfpconfig_aclk,
  input  logic                                  vfpconfig_aresetn,
  input  logic                                  cmd_valid,
  output logic                                  cmd_ready,
  input  logic                                  cmd_write,
  input  logic [C_vfpConfig_ADDR_WIDTH-1:0]     cmd_addr,
  input  logic [C_vfpConfig_DATA_WIDTH-1:0]     cmd_wdata,
  input  logic [C_vfpConfig_DATA_WIDTH/8-1:0]   cmd_wstrb,
  output logic                                  rsp_valid,
  input  logic                                  rsp_ready,
  output logic [C_vfpConfig_DATA_WIDTH-1:0]     rsp_rdata,
  output logic [1:0]                            rsp_resp,
  output logic                                  rsp_timeout,
  output logic                                  busy,
  output logic [C_vfpConfig_ADDR_WIDTH-1:0]     vfpconfig_awaddr,
  output logic [2:0]                            vfpconfig_awprot,
  output logic                                  vfpconfig_awvalid,
  input  logic                                  vfpconfig_awready,
  output logic [C_vfpConfig_DATA_WIDTH-1:0]     vfpconfig_wdata,
  output logic [C_vfpConfig_DATA_WIDTH/8-1:0]   vfpconfig_wstrb,
  output logic                                  vfpconfig_wvalid,
  input  logic                                  vfpconfig_wready,
  input  logic [1:0]                            vfpconfig_bresp,
  input  logic                                  vfpconfig_bvalid,
  output logic                                  vfpconfig_bready,
  output logic [C_vfpConfig_ADDR_WIDTH-1:0]     vfpconfig_araddr,
  output logic [2:0]                            vfpconfig_arprot,
  output logic                                  vfpconfig_arvalid,
  input  logic                                  vfpconfig_arready,
  input  logic [C_vfpConfig_DATA_WIDTH-1:0]     vfpconfig_rdata,
  input  logic [1:0]                            vfpconfig_rresp,
  input  logic                                  vfpconfig_rvalid,
  output logic                                  vfpconfig_rready
);
  localparam int DW = C_vfpConfig_DATA_WIDTH;
  localparam int AW = C_vfpConfig_ADDR_WIDTH;
  localparam int SW = DW / 8;
  localparam logic [15:0] LIMIT = 16'(TIMEOUT_CYCLES - 1);
  typedef enum logic [2:0] {IDLE, WR, WR_RESP, RD, RD_DATA, RSP} state_t;
  state_t state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic [SW-1:0] wstrb_q, wstrb_d;
  logic [1:0] resp_q, resp_d;
  logic cmd_ready_q, cmd_ready_d, busy_q, busy_d, rsp_valid_q, rsp_valid_d, timeout_q, timeout_d;
  logic awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d, arvalid_q, arvalid_d, rready_q, rready_d;
  logic bus, aw_done, w_done, complete, abort;
  assign cmd_ready = cmd_ready_q;
  assign busy = busy_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;
  assign rsp_resp = resp_q;
  assign rsp_timeout = timeout_q;
  assign vfpconfig_awaddr = addr_q;
  assign vfpconfig_araddr = addr_q;
  assign vfpconfig_awprot = 3'b000;
  assign vfpconfig_arprot = 3'b000;
  assign vfpconfig_wdata = wdata_q;
  assign vfpconfig_wstrb = wstrb_q;
  assign vfpconfig_awvalid = awvalid_q;
  assign vfpconfig_wvalid = wvalid_q;
  assign vfpconfig_bready = bready_q;
  assign vfpconfig_arvalid = arvalid_q;
  assign vfpconfig_rready = rready_q;
  assign bus = (state_q == WR) || (state_q == WR_RESP) || (state_q == RD) || (state_q == RD_DATA);
  assign aw_done = !awvalid_q || vfpconfig_awready;
  assign w_done = !wvalid_q || vfpconfig_wready;
  assign complete = ((state_q == WR) && aw_done && w_done) ||
                    ((state_q == WR_RESP) && vfpconfig_bvalid) ||
                    ((state_q == RD) && vfpconfig_arready) ||
                    ((state_q == RD_DATA) && vfpconfig_rvalid);
  assign abort = bus && (cnt_q >= LIMIT) && !complete;
  always_comb begin
    state_d = state_q;
    cnt_d = bus ? cnt_q + 16'd1 : cnt_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    rdata_d = rdata_q;
    resp_d = resp_q;
    cmd_ready_d = cmd_ready_q;
    busy_d = busy_q;
    rsp_valid_d = rsp_valid_q;
    timeout_d = timeout_q;
    awvalid_d = awvalid_q;
    wvalid_d = wvalid_q;
    bready_d = bready_q;
    arvalid_d = arvalid_q;
    rready_d = rready_q;
    unique case (state_q)
      IDLE: if (cmd_valid && cmd_ready_q) begin
        addr_d = cmd_addr;
        wdata_d = cmd_wdata;
        wstrb_d = cmd_wstrb;
        cnt_d = 16'd0;
        cmd_ready_d = 1'b0;
        busy_d = 1'b1;
        state_d = cmd_write ? WR : RD;
        awvalid_d = cmd_write;
        wvalid_d = cmd_write;
        arvalid_d = !cmd_write;
      end
      WR: begin
        awvalid_d = awvalid_q && !vfpconfig_awready;
        wvalid_d = wvalid_q && !vfpconfig_wready;
        if (complete) begin
          state_d = WR_RESP;
          bready_d = 1'b1;
        end
      end
      WR_RESP: if (vfpconfig_bvalid) begin
        state_d = RSP;
        bready_d = 1'b0;
        rsp_valid_d = 1'b1;
        resp_d = vfpconfig_bresp;
        rdata_d = '0;
        timeout_d = 1'b0;
      end
      RD: if (vfpconfig_arready) begin
        state_d = RD_DATA;
        arvalid_d = 1'b0;
        rready_d = 1'b1;
      end
      RD_DATA: if (vfpconfig_rvalid) begin
        state_d = RSP;
        rready_d = 1'b0;
        rsp_valid_d = 1'b1;
        resp_d = vfpconfig_rresp;
        rdata_d = vfpconfig_rdata;
        timeout_d = 1'b0;
      end
      RSP: if (rsp_ready) begin
        state_d = IDLE;
        rsp_valid_d = 1'b0;
        busy_d = 1'b0;
        cmd_ready_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    if (abort) begin
      state_d = RSP;
      awvalid_d = 1'b0;
      wvalid_d = 1'b0;
      bready_d = 1'b0;
      arvalid_d = 1'b0;
      rready_d = 1'b0;
      rsp_valid_d = 1'b1;
      timeout_d = 1'b1;
      resp_d = 2'b10;
      rdata_d = '0;
    end
  end
  always_ff @(posedge vfpconfig_aclk or negedge vfpconfig_aresetn) begin
    if (!vfpconfig_aresetn) begin
      state_q <= IDLE;
      cnt_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rdata_q <= '0;
      resp_q <= '0;
      cmd_ready_q <= 1'b1;
      busy_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      timeout_q <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q <= 1'b0;
      bready_q <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      rdata_q <= rdata_d;
      resp_q <= resp_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q <= busy_d;
      rsp_valid_q <= rsp_valid_d;
      timeout_q <= timeout_d;
      awvalid_q <= awvalid_d;
      wvalid_q <= wvalid_d;
      bready_q <= bready_d;
      arvalid_q <= arvalid_d;
      rready_q <= rready_d;
    end
  end
endmodule

// File: tb/tb_vfp_config_axil_master.sv
// tb_vfp_config_axil_master: directed self-checking bench for the AXI-Lite config initiator
module tb_vfp_config_axil_master;
  logic clk = 1'b0;
  logic aresetn;
  logic cmd_valid, cmd_ready, cmd_write;
  logic [7:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0] cmd_wstrb;
  logic rsp_valid, rsp_ready, rsp_timeout, busy;
  logic [31:0] rsp_rdata;
  logic [1:0] rsp_resp;
  logic [7:0] awaddr, araddr;
  logic [2:0] awprot, arprot;
  logic awvalid, awready, wvalid, wready, bvalid, bready, arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [3:0] wstrb;
  logic [1:0] bresp, rresp;
  logic [31:0] mem [64];
  int n_assert = 0;
  int n_fail = 0;
  vfp_config_axil_master #(
    .C_vfpConfig_DATA_WIDTH(32),
    .C_vfpConfig_ADDR_WIDTH(8),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .vfpconfig_aclk(clk),
    .vfpconfig_aresetn(aresetn),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_write(cmd_write),
    .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata),
    .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp),
    .rsp_timeout(rsp_timeout),
    .busy(busy),
    .vfpconfig_awaddr(awaddr),
    .vfpconfig_awprot(awprot),
    .vfpconfig_awvalid(awvalid),
    .vfpconfig_awready(awready),
    .vfpconfig_wdata(wdata),
    .vfpconfig_wstrb(wstrb),
    .vfpconfig_wvalid(wvalid),
    .vfpconfig_wready(wready),
    .vfpconfig_bresp(bresp),
    .vfpconfig_bvalid(bvalid),
    .vfpconfig_bready(bready),
    .vfpconfig_araddr(araddr),
    .vfpconfig_arprot(arprot),
    .vfpconfig_arvalid(arvalid),
    .vfpconfig_arready(arready),
    .vfpconfig_rdata(rdata),
    .vfpconfig_rresp(rresp),
    .vfpconfig_rvalid(rvalid),
    .vfpconfig_rready(rready)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic issue(input logic wr, input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr = a;
    cmd_wdata = d;
    cmd_wstrb = s;
    tick();
    cmd_valid = 1'b0;
  endtask
  task automatic finish_rsp();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("rsp_drop", {31'd0, rsp_valid}, 32'd0);
    chk("cmd_ready_back", {31'd0, cmd_ready}, 32'd1);
    chk("busy_idle", {31'd0, busy}, 32'd0);
  endtask
  task automatic do_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
    issue(1'b1, a, d, s);
    chk("wr_awvalid", {31'd0, awvalid}, 32'd1);
    chk("wr_wvalid", {31'd0, wvalid}, 32'd1);
    chk("wr_awaddr", {24'd0, awaddr}, {24'd0, a});
    chk("wr_wdata", wdata, d);
    chk("wr_wstrb", {28'd0, wstrb}, {28'd0, s});
    chk("wr_busy", {31'd0, busy}, 32'd1);
    chk("wr_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    if (awvalid && awready && wvalid && wready) mem[a[7:2]] = wdata;
    tick();
    chk("wr_aw_drop", {31'd0, awvalid}, 32'd0);
    chk("wr_w_drop", {31'd0, wvalid}, 32'd0);
    chk("wr_bready", {31'd0, bready}, 32'd1);
    chk("wr_no_rsp_yet", {31'd0, rsp_valid}, 32'd0);
    bvalid = 1'b1;
    bresp = 2'b00;
    tick();
    bvalid = 1'b0;
    chk("wr_rsp_valid_t3", {31'd0, rsp_valid}, 32'd1);
    chk("wr_rsp_resp", {30'd0, rsp_resp}, 32'd0);
    chk("wr_rsp_timeout", {31'd0, rsp_timeout}, 32'd0);
    chk("wr_rsp_rdata", rsp_rdata, 32'd0);
    chk("wr_bready_drop", {31'd0, bready}, 32'd0);
    chk("wr_rsp_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    finish_rsp();
  endtask
  task automatic do_read(input logic [7:0] a, input logic [31:0] exp);
    issue(1'b0, a, 32'd0, 4'd0);
    chk("rd_arvalid", {31'd0, arvalid}, 32'd1);
    chk("rd_araddr", {24'd0, araddr}, {24'd0, a});
    chk("rd_arprot", {29'd0, arprot}, 32'd0);
    tick();
    chk("rd_ar_drop", {31'd0, arvalid}, 32'd0);
    chk("rd_rready", {31'd0, rready}, 32'd1);
    rvalid = 1'b1;
    rdata = mem[a[7:2]];
    rresp = 2'b00;
    tick();
    rvalid = 1'b0;
    rdata = 32'd0;
    chk("rd_rsp_valid_t3", {31'd0, rsp_valid}, 32'd1);
    chk("rd_rsp_rdata", rsp_rdata, exp);
    chk("rd_rsp_resp", {30'd0, rsp_resp}, 32'd0);
    chk("rd_rsp_timeout", {31'd0, rsp_timeout}, 32'd0);
    finish_rsp();
  endtask
  initial begin
    int k;
    for (int i = 0; i < 64; i++) mem[i] = 32'd0;
    aresetn = 1'b0;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr = 8'd0;
    cmd_wdata = 32'd0;
    cmd_wstrb = 4'd0;
    rsp_ready = 1'b0;
    awready = 1'b1;
    wready = 1'b1;
    arready = 1'b1;
    bvalid = 1'b0;
    bresp = 2'b00;
    rvalid = 1'b0;
    rdata = 32'd0;
    rresp = 2'b00;
    tick();
    tick();
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("rst_valids", {27'd0, awvalid, wvalid, arvalid, bready, rready}, 32'd0);
    chk("rst_rsp", {rsp_rdata[29:0], rsp_valid, rsp_timeout} | {30'd0, rsp_resp}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_addr_data", {awaddr, araddr, 12'd0, wstrb} | wdata, 32'd0);
    aresetn = 1'b1;
    tick();
    do_write(8'h04, 32'h0000_00A5, 4'hF);
    wready = 1'b0;
    issue(1'b1, 8'h0C, 32'h1234_5678, 4'h3);
    chk("dly_both_valid", {30'd0, awvalid, wvalid}, 32'd3);
    tick();
    chk("dly_aw_drop", {31'd0, awvalid}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      chk("dly_w_held", {31'd0, wvalid}, 32'd1);
      chk("dly_wdata_stable", wdata, 32'h1234_5678);
      chk("dly_no_bready", {31'd0, bready}, 32'd0);
      tick();
    end
    wready = 1'b1;
    chk("dly_w_still", {31'd0, wvalid}, 32'd1);
    tick();
    chk("dly_w_drop", {31'd0, wvalid}, 32'd0);
    chk("dly_bready", {31'd0, bready}, 32'd1);
    bvalid = 1'b1;
    tick();
    bvalid = 1'b0;
    chk("dly_bready_once", {31'd0, bready}, 32'd0);
    chk("dly_rsp", {29'd0, rsp_valid, rsp_resp}, 32'd4);
    finish_rsp();
    do_write(8'h08, 32'hCAFE_F00D, 4'hF);
    do_read(8'h08, 32'hCAFE_F00D);
    arready = 1'b0;
    issue(1'b0, 8'h10, 32'd0, 4'd0);
    k = 0;
    while (arvalid && k < 40) begin
      k++;
      tick();
    end
    chk("to_arvalid_cycles", k, 32'd16);
    chk("to_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("to_flag", {31'd0, rsp_timeout}, 32'd1);
    chk("to_resp", {30'd0, rsp_resp}, 32'd2);
    chk("to_rdata", rsp_rdata, 32'd0);
    chk("to_rready", {31'd0, rready}, 32'd0);
    finish_rsp();
    arready = 1'b1;
    do_write(8'h14, 32'h0BAD_F00D, 4'hC);
    arready = 1'b0;
    issue(1'b0, 8'h18, 32'd0, 4'd0);
    repeat (15) tick();
    chk("edge_arvalid_last", {31'd0, arvalid}, 32'd1);
    arready = 1'b1;
    tick();
    chk("edge_ar_wins", {30'd0, arvalid, rready}, 32'd1);
    chk("edge_no_abort", {31'd0, rsp_valid}, 32'd0);
    rvalid = 1'b1;
    rdata = 32'h0000_55AA;
    tick();
    rvalid = 1'b0;
    chk("edge_rsp", {30'd0, rsp_valid, rsp_timeout}, 32'd2);
    chk("edge_rdata", rsp_rdata, 32'h0000_55AA);
    finish_rsp();
    issue(1'b0, 8'h20, 32'd0, 4'd0);
    tick();
    rvalid = 1'b1;
    rdata = 32'hDEAD_BEEF;
    rresp = 2'b10;
    tick();
    rvalid = 1'b0;
    rdata = 32'd0;
    rresp = 2'b00;
    for (int i = 0; i < 4; i++) begin
      chk("slverr_valid", {31'd0, rsp_valid}, 32'd1);
      chk("slverr_rdata", rsp_rdata, 32'hDEAD_BEEF);
      chk("slverr_resp", {30'd0, rsp_resp}, 32'd2);
      chk("slverr_cmd_ready", {31'd0, cmd_ready}, 32'd0);
      tick();
    end
    rsp_ready = 1'b1;
    chk("slverr_exit_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    tick();
    rsp_ready = 1'b0;
    chk("slverr_done", {30'd0, rsp_valid, cmd_ready}, 32'd1);
    issue(1'b1, 8'h24, 32'h7777_0000, 4'hF);
    tick();
    chk("rst_in_wr_resp", {31'd0, bready}, 32'd1);
    #2;
    aresetn = 1'b0;
    #1;
    chk("arst_valids", {27'd0, awvalid, wvalid, arvalid, bready, rready}, 32'd0);
    chk("arst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    tick();
    aresetn = 1'b1;
    bvalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("arst_no_rsp", {31'd0, rsp_valid}, 32'd0);
      chk("arst_no_bready", {31'd0, bready}, 32'd0);
    end
    bvalid = 1'b0;
    do_write(8'h28, 32'h1357_9BDF, 4'hF);
    do_read(8'h28, 32'h1357_9BDF);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/vfp_config_axil_master.md
Name: vfp_config_axil_master

Overview:
- AXI4-Lite initiator that drives the VFP_v1_0 vfpconfig_* register slave from a simple command/response port.
- One transaction in flight at a time.
- Sits in the test harness and bring-up logic between a register sequencer (bench or CPU-less boot ROM) and the vfpconfig slave.
- Has a per-transaction timeout, so a hung slave produces an error response instead of a deadlock.

Parameters:
- C_vfpConfig_DATA_WIDTH, 32, AXI-Lite data width; must be 32.
- C_vfpConfig_ADDR_WIDTH, 8, AXI-Lite byte address width.
- TIMEOUT_CYCLES, 256, bus cycles allowed per transaction before abort; valid range 2..65535.

Ports:
- vfpconfig_aclk  in  1  single clock for everything.
- vfpconfig_aresetn  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when high together with cmd_valid.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_WIDTH  byte address.
- cmd_wdata  in  DATA_WIDTH  write data.
- cmd_wstrb  in  DATA_WIDTH/8  write strobes.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed.
- rsp_rdata  out  DATA_WIDTH  read data (0 for writes).
- rsp_resp  out  2  AXI response, or 2'b10 on timeout.
- rsp_timeout  out  1  transaction aborted by timeout.
- busy  out  1  FSM not in IDLE.
- vfpconfig_awaddr/awprot/awvalid  out  ADDR_WIDTH/3/1.
- vfpconfig_awready  in  1.
- vfpconfig_wdata/wstrb/wvalid  out  DATA_WIDTH/DATA_WIDTH/8/1.
- vfpconfig_wready  in  1.
- vfpconfig_bresp  in  2.
- vfpconfig_bvalid  in  1.
- vfpconfig_bready  out  1.
- vfpconfig_araddr/arprot/arvalid  out  ADDR_WIDTH/3/1.
- vfpconfig_arready  in  1.
- vfpconfig_rdata  in  DATA_WIDTH.
- vfpconfig_rresp  in  2.
- vfpconfig_rvalid  in  1.
- vfpconfig_rready  out  1.

Behaviour:
- Reset:
  - All valid/ready outputs are 0, except cmd_ready = 1.
  - Address, data and strobe outputs are 0; rsp_* are 0; busy = 0; FSM is in IDLE; timeout counter is 0.
  - Reset asserted mid-transaction drops every valid immediately and discards the transaction; no response is produced.
- States: IDLE, WR, WR_RESP, RD, RD_DATA, RSP.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid && cmd_ready, register addr, wdata and wstrb.
  - Go to WR if cmd_write = 1, else RD.
  - Bus valids rise on the cycle after acceptance.
- WR:
  - awvalid and wvalid both assert on entry.
  - Each drops independently on the cycle after its own handshake (awvalid&&awready, wvalid&&wready).
  - When both handshakes are done (same cycle or different cycles), go to WR_RESP.
  - awaddr and wdata stay stable while their valid is high.
- WR_RESP:
  - bready = 1.
  - On bvalid, capture bresp into rsp_resp, set rsp_rdata = 0, go to RSP.
- RD:
  - arvalid = 1; on arready go to RD_DATA and drop arvalid.
- RD_DATA:
  - rready = 1.
  - On rvalid, capture rdata and rresp, go to RSP.
- RSP:
  - rsp_valid = 1, held with stable data until rsp_ready.
  - Then go to IDLE; cmd_ready rises the following cycle, so there is no back-to-back accept in the RSP exit cycle.
- awprot and arprot are fixed at 3'b000.
- Timeout:
  - The counter clears on command accept and increments every cycle in WR, WR_RESP, RD and RD_DATA.
  - When the count reaches TIMEOUT_CYCLES-1 without completion, drop all bus valids and readies next cycle.
  - Then go to RSP with rsp_timeout = 1, rsp_resp = 2'b10, rsp_rdata = 0.
  - Late bvalid or rvalid after abort is ignored because bready and rready are 0.
  - A handshake completing in the same cycle the counter reaches its limit takes precedence over the timeout.
- Latency with a zero-wait slave:
  - Write: accept at T0; aw and w handshakes at T1; bvalid at T2; rsp_valid at T3.
  - Read: arvalid at T1; rvalid at T2; rsp_valid at T3.
- busy = 1 in every state except IDLE.
- No pipelining: exactly one outstanding transaction.

Test Plan:
- Write 0x0000_00A5 to addr 0x04 with wstrb 0xF, slave accepts aw and w in the same cycle with 0 wait → one aw and one w handshake, rsp_resp = 00, rsp_timeout = 0, rsp_valid 3 cycles after accept.
- Write with wready delayed 5 cycles after awready → awvalid low after its handshake, wvalid held with stable data until wready, exactly one bready handshake, rsp_resp = 00.
- Write to 0x08, then read 0x08 on the real VFP slave → rsp_rdata = written value, rsp_resp = 00.
- Read where the slave never asserts arready, TIMEOUT_CYCLES = 16 → arvalid drops after 16 bus cycles, rsp_timeout = 1, rsp_resp = 10, rsp_rdata = 0, next command is accepted normally.
- Slave returns rresp = 10 with rdata 0xDEAD_BEEF, rsp_ready held low 4 cycles → rsp_valid with stable rsp_rdata = 0xDEADBEEF and rsp_resp = 10 for 4 cycles, cmd_ready stays 0 until the cycle after rsp_ready.
- Assert aresetn low while in WR_RESP → all valids 0 and cmd_ready = 1 asynchronously, no rsp_valid after reset release.
